// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares a single-port memory between an instruction-fetch requester and a
// data requester. One transaction is in flight at a time. When both sides ask
// in the same idle cycle, the side that was not granted last wins.
//
// Ports
//   clk, rst_n        : clock, synchronous active-low reset
//   i_req/i_addr      : fetch request and address (held until i_ack)
//   i_rdata/i_ack     : fetched instruction and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : data request, direction, address, write data
//   d_rdata/d_ack     : read data and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata : request toward the shared memory
//   m_rdata/m_ack     : memory read data and one-cycle completion
//
// All outputs come straight from flops.

module mem_arbiter #(
  parameter int WORD      = 64,
  parameter int INST_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [WORD-1:0]      i_addr,
  output logic [INST_SIZE-1:0] i_rdata,
  output logic                 i_ack,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD-1:0]      d_addr,
  input  logic [WORD-1:0]      d_wdata,
  output logic [WORD-1:0]      d_rdata,
  output logic                 d_ack,
  output logic                 m_req,
  output logic                 m_we,
  output logic [WORD-1:0]      m_addr,
  output logic [WORD-1:0]      m_wdata,
  input  logic [WORD-1:0]      m_rdata,
  input  logic                 m_ack
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  // Last-grant pointer: 0 = instruction side, 1 = data side.
  logic                   lastD_q, lastD_d;
  logic                   mReq_q, mReq_d;
  logic                   mWe_q, mWe_d;
  logic [WORD-1:0]        mAddr_q, mAddr_d;
  logic [WORD-1:0]        mWdata_q, mWdata_d;
  logic [INST_SIZE-1:0]   iRdata_q, iRdata_d;
  logic [WORD-1:0]        dRdata_q, dRdata_d;
  logic                   iAck_q, iAck_d;
  logic                   dAck_q, dAck_d;

  // Next-state and next-output logic. Acks are computed on the edge that
  // enters DONE_x so they are high for exactly the DONE_x cycle. m_ack is
  // only looked at in the BUSY states, so stray pulses elsewhere are inert.
  always_comb begin
    state_d  = state_q;
    lastD_d  = lastD_q;
    mReq_d   = mReq_q;
    mWe_d    = mWe_q;
    mAddr_d  = mAddr_q;
    mWdata_d = mWdata_q;
    iRdata_d = iRdata_q;
    dRdata_d = dRdata_q;
    iAck_d   = 1'b0;
    dAck_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins when it is alone, or when both ask and instruction
        // was the previous winner.
        if (d_req && (!i_req || !lastD_q)) begin
          state_d  = BUSY_D;
          lastD_d  = 1'b1;
          mReq_d   = 1'b1;
          mWe_d    = d_we;
          mAddr_d  = d_addr;
          mWdata_d = d_wdata;
        end else if (i_req) begin
          state_d  = BUSY_I;
          lastD_d  = 1'b0;
          mReq_d   = 1'b1;
          mWe_d    = 1'b0;
          mAddr_d  = i_addr;
          mWdata_d = '0;
        end
      end
      BUSY_I: begin
        if (m_ack) begin
          state_d  = DONE_I;
          mReq_d   = 1'b0;
          iRdata_d = m_rdata[INST_SIZE-1:0];
          iAck_d   = 1'b1;
        end
      end
      BUSY_D: begin
        if (m_ack) begin
          state_d = DONE_D;
          mReq_d  = 1'b0;
          // A write returns nothing, so the previous read data is kept.
          if (!mWe_q) dRdata_d = m_rdata;
          dAck_d  = 1'b1;
        end
      end
      DONE_I, DONE_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset also aborts
  // any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lastD_q  <= 1'b0;
      mReq_q   <= 1'b0;
      mWe_q    <= 1'b0;
      mAddr_q  <= '0;
      mWdata_q <= '0;
      iRdata_q <= '0;
      dRdata_q <= '0;
      iAck_q   <= 1'b0;
      dAck_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lastD_q  <= lastD_d;
      mReq_q   <= mReq_d;
      mWe_q    <= mWe_d;
      mAddr_q  <= mAddr_d;
      mWdata_q <= mWdata_d;
      iRdata_q <= iRdata_d;
      dRdata_q <= dRdata_d;
      iAck_q   <= iAck_d;
      dAck_q   <= dAck_d;
    end
  end

  assign m_req   = mReq_q;
  assign m_we    = mWe_q;
  assign m_addr  = mAddr_q;
  assign m_wdata = mWdata_q;
  assign i_rdata = iRdata_q;
  assign i_ack   = iAck_q;
  assign d_rdata = dRdata_q;
  assign d_ack   = dAck_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. The memory side is driven by hand so each
// scenario controls exactly when m_ack arrives. Inputs change 1 ns after the
// rising edge and outputs are sampled at that same point.

module tb_mem_arbiter;

  localparam int WORD      = 64;
  localparam int INST_SIZE = 32;

  logic                 clk;
  logic                 rst_n;
  logic                 i_req;
  logic [WORD-1:0]      i_addr;
  logic [INST_SIZE-1:0] i_rdata;
  logic                 i_ack;
  logic                 d_req;
  logic                 d_we;
  logic [WORD-1:0]      d_addr;
  logic [WORD-1:0]      d_wdata;
  logic [WORD-1:0]      d_rdata;
  logic                 d_ack;
  logic                 m_req;
  logic                 m_we;
  logic [WORD-1:0]      m_addr;
  logic [WORD-1:0]      m_wdata;
  logic [WORD-1:0]      m_rdata;
  logic                 m_ack;

  int compared;
  int mismatched;

  mem_arbiter #(.WORD(WORD), .INST_SIZE(INST_SIZE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ack   (d_ack),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one cycle and land just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    compared += 8;
    if (m_req !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_req got=%0b exp=0", m_req); end
    if (m_we !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_we got=%0b exp=0", m_we); end
    if (m_addr !== '0) begin mismatched++; $display("[TB] FAIL reset_m_addr got=%h exp=0", m_addr); end
    if (m_wdata !== '0) begin mismatched++; $display("[TB] FAIL reset_m_wdata got=%h exp=0", m_wdata); end
    if (i_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_i_ack got=%0b exp=0", i_ack); end
    if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_d_ack got=%0b exp=0", d_ack); end
    if (i_rdata !== '0) begin mismatched++; $display("[TB] FAIL reset_i_rdata got=%h exp=0", i_rdata); end
    if (d_rdata !== '0) begin mismatched++; $display("[TB] FAIL reset_d_rdata got=%h exp=0", d_rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_lone_fetch();
    i_req  = 1'b1;
    i_addr = 64'h40;
    tick();
    compared += 3;
    if (m_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_m_req got=%0b exp=1", m_req); end
    if (m_addr !== 64'h40) begin mismatched++; $display("[TB] FAIL fetch_m_addr got=%h exp=40", m_addr); end
    if (m_we !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_m_we got=%0b exp=0", m_we); end
    tick();
    compared += 2;
    if (m_req !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_m_req_hold got=%0b exp=1", m_req); end
    if (i_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_early_ack got=%0b exp=0", i_ack); end
    m_ack   = 1'b1;
    m_rdata = 64'hAAAA_BBBB_8B02_0020;
    tick();
    m_ack = 1'b0;
    compared += 3;
    if (i_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL fetch_i_ack got=%0b exp=1", i_ack); end
    if (i_rdata !== 32'h8B02_0020) begin mismatched++; $display("[TB] FAIL fetch_i_rdata got=%h exp=8b020020", i_rdata); end
    if (m_req !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_m_req_drop got=%0b exp=0", m_req); end
    i_req = 1'b0;
    tick();
    compared += 1;
    if (i_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL fetch_ack_pulse got=%0b exp=0", i_ack); end
  endtask

  task automatic test_lone_write();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h100;
    d_wdata = 64'h1234;
    tick();
    compared += 4;
    if (m_req !== 1'b1) begin mismatched++; $display("[TB] FAIL write_m_req got=%0b exp=1", m_req); end
    if (m_we !== 1'b1) begin mismatched++; $display("[TB] FAIL write_m_we got=%0b exp=1", m_we); end
    if (m_addr !== 64'h100) begin mismatched++; $display("[TB] FAIL write_m_addr got=%h exp=100", m_addr); end
    if (m_wdata !== 64'h1234) begin mismatched++; $display("[TB] FAIL write_m_wdata got=%h exp=1234", m_wdata); end
    m_ack   = 1'b1;
    m_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    m_ack = 1'b0;
    compared += 3;
    if (d_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL write_d_ack got=%0b exp=1", d_ack); end
    if (d_rdata !== '0) begin mismatched++; $display("[TB] FAIL write_d_rdata got=%h exp=0", d_rdata); end
    if (i_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL write_i_ack got=%0b exp=0", i_ack); end
    d_req = 1'b0;
    d_we  = 1'b0;
    tick();
    compared += 1;
    if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL write_ack_pulse got=%0b exp=0", d_ack); end
  endtask

  // Both sides hold their requests; winners must alternate D, I, D, I
  // with zero-wait memory completing in the first BUSY cycle.
  task automatic test_conflict();
    logic [WORD-1:0] rdTbl [4];
    logic            winD;
    rdTbl[0] = 64'hD0D0_0000_0000_0D00;
    rdTbl[1] = 64'hFFFF_FFFF_1111_0001;
    rdTbl[2] = 64'hD0D0_0000_0000_0D02;
    rdTbl[3] = 64'hFFFF_FFFF_3333_0003;
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    i_addr = 64'h200;
    d_addr = 64'h300;
    d_we   = 1'b0;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int r = 0; r < 4; r++) begin
      winD = (r % 2 == 0);
      tick();
      compared += 1;
      if (m_addr !== (winD ? 64'h300 : 64'h200))
        begin mismatched++; $display("[TB] FAIL conflict_grant r=%0d got=%h exp=%h", r, m_addr, winD ? 64'h300 : 64'h200); end
      m_ack   = 1'b1;
      m_rdata = rdTbl[r];
      tick();
      m_ack = 1'b0;
      compared += 3;
      if (d_ack !== winD) begin mismatched++; $display("[TB] FAIL conflict_d_ack r=%0d got=%0b exp=%0b", r, d_ack, winD); end
      if (i_ack !== !winD) begin mismatched++; $display("[TB] FAIL conflict_i_ack r=%0d got=%0b exp=%0b", r, i_ack, !winD); end
      if (winD) begin
        if (d_rdata !== rdTbl[r]) begin mismatched++; $display("[TB] FAIL conflict_d_rdata r=%0d got=%h exp=%h", r, d_rdata, rdTbl[r]); end
        d_req = 1'b0;
      end else begin
        if (i_rdata !== rdTbl[r][31:0]) begin mismatched++; $display("[TB] FAIL conflict_i_rdata r=%0d got=%h exp=%h", r, i_rdata, rdTbl[r][31:0]); end
        i_req = 1'b0;
      end
      tick();
      if (winD) d_req = 1'b1;
      else      i_req = 1'b1;
    end
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic test_stall();
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = 64'h500;
    tick();
    for (int c = 0; c < 5; c++) begin
      compared += 3;
      if (m_req !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_m_req c=%0d got=%0b exp=1", c, m_req); end
      if (m_addr !== 64'h500) begin mismatched++; $display("[TB] FAIL stall_m_addr c=%0d got=%h exp=500", c, m_addr); end
      if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_d_ack c=%0d got=%0b exp=0", c, d_ack); end
      tick();
    end
    m_ack   = 1'b1;
    m_rdata = 64'h77;
    tick();
    m_ack = 1'b0;
    compared += 2;
    if (d_ack !== 1'b1) begin mismatched++; $display("[TB] FAIL stall_done_ack got=%0b exp=1", d_ack); end
    if (d_rdata !== 64'h77) begin mismatched++; $display("[TB] FAIL stall_d_rdata got=%h exp=77", d_rdata); end
    d_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      compared += 1;
      if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL stall_extra_ack c=%0d got=%0b exp=0", c, d_ack); end
    end
  endtask

  task automatic test_spurious_ack();
    m_ack   = 1'b1;
    m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int c = 0; c < 2; c++) begin
      tick();
      compared += 5;
      if (i_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL spur_i_ack c=%0d got=%0b exp=0", c, i_ack); end
      if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL spur_d_ack c=%0d got=%0b exp=0", c, d_ack); end
      if (m_req !== 1'b0) begin mismatched++; $display("[TB] FAIL spur_m_req c=%0d got=%0b exp=0", c, m_req); end
      if (i_rdata !== 32'h3333_0003) begin mismatched++; $display("[TB] FAIL spur_i_rdata c=%0d got=%h exp=33330003", c, i_rdata); end
      if (d_rdata !== 64'h77) begin mismatched++; $display("[TB] FAIL spur_d_rdata c=%0d got=%h exp=77", c, d_rdata); end
    end
    m_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h600;
    d_wdata = 64'h99;
    tick();
    compared += 1;
    if (m_req !== 1'b1) begin mismatched++; $display("[TB] FAIL rmid_busy got=%0b exp=1", m_req); end
    rst_n = 1'b0;
    tick();
    rst_n   = 1'b1;
    d_req   = 1'b0;
    d_we    = 1'b0;
    m_ack   = 1'b1;
    m_rdata = 64'h55;
    tick();
    m_ack = 1'b0;
    compared += 7;
    if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_d_ack got=%0b exp=0", d_ack); end
    if (m_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_m_req got=%0b exp=0", m_req); end
    if (m_we !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_m_we got=%0b exp=0", m_we); end
    if (m_addr !== '0) begin mismatched++; $display("[TB] FAIL rmid_m_addr got=%h exp=0", m_addr); end
    if (m_wdata !== '0) begin mismatched++; $display("[TB] FAIL rmid_m_wdata got=%h exp=0", m_wdata); end
    if (d_rdata !== '0) begin mismatched++; $display("[TB] FAIL rmid_d_rdata got=%h exp=0", d_rdata); end
    if (i_rdata !== '0) begin mismatched++; $display("[TB] FAIL rmid_i_rdata got=%h exp=0", i_rdata); end
    tick();
    compared += 2;
    if (d_ack !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_late_ack got=%0b exp=0", d_ack); end
    if (m_req !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_idle got=%0b exp=0", m_req); end
  endtask

  // Scenarios run in order; later ones rely on data left by earlier ones.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    m_rdata = '0;
    m_ack   = 1'b0;
    test_reset();
    test_lone_fetch();
    test_lone_write();
    test_conflict();
    test_stall();
    test_spurious_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD, default 64, data/address width in bits.
REQ-002 Parameter INST_SIZE, default 32, instruction width in bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_req  input  1  instruction-fetch request, held high until i_ack.
REQ-006 i_addr  input  WORD  fetch address, stable while i_req high.
REQ-007 i_rdata  output  INST_SIZE  fetched instruction.
REQ-008 i_ack  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request, held high until d_ack.
REQ-010 d_we  input  1  1 = write, 0 = read; stable while d_req high.
REQ-011 d_addr  input  WORD  data address.
REQ-012 d_wdata  input  WORD  write data.
REQ-013 d_rdata  output  WORD  read data.
REQ-014 d_ack  output  1  one-cycle data completion pulse.
REQ-015 m_req  output  1  request to the shared single-port memory.
REQ-016 m_we  output  1  memory write enable.
REQ-017 m_addr  output  WORD  memory address.
REQ-018 m_wdata  output  WORD  memory write data.
REQ-019 m_rdata  input  WORD  memory read data, valid when m_ack high.
REQ-020 m_ack  input  1  memory completion, high exactly one cycle per m_req transaction.

Function
REQ-021 All outputs SHALL be registered.
REQ-022 FSM states SHALL be IDLE, BUSY_I, BUSY_D, DONE_I, DONE_D.
REQ-023 IDLE: no req -> stay; only i_req -> BUSY_I; only d_req -> BUSY_D; both -> the requester not served last (last-grant pointer).
REQ-024 Last-grant pointer SHALL update to the winner on each grant; both requesting with pointer = I SHALL grant D.
REQ-025 On grant edge, m_addr/m_we/m_wdata SHALL latch winner's inputs (i path: m_we=0, m_wdata=0) and m_req SHALL go high.
REQ-026 m_req, m_addr, m_we, m_wdata SHALL stay constant throughout BUSY_x.
REQ-027 BUSY_x with m_ack=1 -> DONE_x; m_req low on same edge; rdata captured on same edge.
REQ-028 BUSY_I capture: i_rdata <= m_rdata[INST_SIZE-1:0]; BUSY_D read capture: d_rdata <= m_rdata.
REQ-029 Data write SHALL leave d_rdata unchanged.
REQ-030 DONE_x: x_ack=1 for exactly that cycle, then unconditionally -> IDLE.
REQ-031 Requester SHALL drop req by the edge ending DONE_x; IDLE re-arbitrates using current req values.
REQ-032 Minimum latency, req high in IDLE at cycle t, zero-wait memory (m_ack at t+1): ack at t+2; next grant earliest t+3.
REQ-033 m_ack in IDLE or DONE_x SHALL be ignored (no state, data or ack change).
REQ-034 Requests arriving during BUSY/DONE SHALL wait; no request is lost while its req stays high.
REQ-035 i_rdata/d_rdata SHALL hold their last captured value until the next capture.

Reset
REQ-036 rst_n=0 at an edge: state IDLE, pointer = I, m_req=0, m_we=0, m_addr=0, m_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0.
REQ-037 Reset mid-transaction SHALL abort it: no ack issued, m_req low next cycle, any later m_ack ignored.

Verification
REQ-038 Lone fetch: i_req=1, i_addr=0x40; m_ack at 2nd BUSY cycle with m_rdata=0xAAAA_BBBB_8B02_0020 -> m_addr=0x40, m_we=0, i_rdata=0x8B020020, i_ack one pulse.
REQ-039 Lone write: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x1234 -> m_we=1, m_addr=0x100, m_wdata=0x1234, d_ack pulse, d_rdata unchanged (0).
REQ-040 Conflict after reset: i_req and d_req both high same cycle -> D served first, then I; repeated conflicts alternate D,I,D,I.
REQ-041 Stalled memory: m_ack delayed 5 cycles -> m_req and m_addr stable all 5 cycles; exactly one ack.
REQ-042 Reset in BUSY_D, then m_ack=1 -> no d_ack, state IDLE, all outputs at reset values.
REQ-043 Spurious m_ack=1 in IDLE with no requests -> no ack, rdata unchanged.
